// File: rtl/volt_pkg.sv
// volt_pkg: word width and sign-magnitude <-> two's complement helpers for the volt datapath
package volt_pkg;
  localparam int DW = 16;
  localparam int SB = DW - 1;
  function automatic logic signed [DW:0] sm2tc(input logic [DW-1:0] x);
    logic signed [DW:0] m;
    m = {2'b00, x[SB-1:0]};
    return x[SB] ? -m : m;
  endfunction
  function automatic logic [DW-1:0] tc2sm(input logic signed [DW:0] v);
    return {v[DW], SB'(v[DW] ? -v : v)};
  endfunction
endpackage

// File: rtl/volt_peak_trk.sv
// volt_peak_trk: window min/max trackers with pk-pk output, registered on fire
module volt_peak_trk
  import volt_pkg::*;
(
  input  logic                 ad_clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 s1_valid,
  input  logic                 first,
  input  logic signed [DW:0]   s1,
  input  logic                 fire,
  output logic [DW-1:0]        max_out,
  output logic [DW-1:0]        min_out,
  output logic [DW-1:0]        pkpk_out
);
  logic signed [DW:0] mx, mn;
  always_ff @(posedge ad_clk)
    if (rst || clear) begin
      mx <= '0;
      mn <= '0;
    end else if (s1_valid) begin
      mx <= (first || s1 > mx) ? s1 : mx;
      mn <= (first || s1 < mn) ? s1 : mn;
    end
  always_ff @(posedge ad_clk)
    if (rst) begin
      max_out  <= '0;
      min_out  <= '0;
      pkpk_out <= '0;
    end else if (fire && !clear) begin
      max_out  <= tc2sm(mx);
      min_out  <= tc2sm(mn);
      pkpk_out <= DW'(mx - mn);
    end
endmodule

// File: rtl/volt_win_avg.sv
// volt_win_avg: 2^LOG2_N-sample block averager on sign-magnitude mV words.
// Define VOLT_PEAK_TRK_EN to add window min/max/pk-pk outputs.
module volt_win_avg
  import volt_pkg::*;
#(
  parameter int LOG2_N = 8
) (
  input  logic          ad_clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] data_in,
  input  logic          clear,
  output logic [DW-1:0] avg_out,
  output logic          avg_valid,
  output logic [DW-1:0] max_out,
  output logic [DW-1:0] min_out,
  output logic [DW-1:0] pkpk_out
);
  localparam int AW = DW + 1 + LOG2_N;
  logic signed [DW:0]   s1, avg_n, avg_tc;
  logic                 s1_valid, done, last;
  logic [LOG2_N-1:0]    cnt;
  logic signed [AW-1:0] acc, ext, tot;
  assign last  = &cnt;
  assign ext   = {{LOG2_N{s1[DW]}}, s1};
  assign tot   = (cnt == '0 ? '0 : acc) + ext;
  assign avg_n = (DW+1)'(tot >>> LOG2_N);
  always_ff @(posedge ad_clk)
    if (rst || clear) begin
      s1        <= '0;
      s1_valid  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      done      <= 1'b0;
      avg_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      if (in_valid) s1 <= sm2tc(data_in);
      done      <= s1_valid && last;
      avg_valid <= done;
      if (s1_valid) begin
        acc <= tot;
        cnt <= cnt + LOG2_N'(1);
      end
    end
  // avg_tc/avg_out survive clear; only rst returns them to zero
  always_ff @(posedge ad_clk)
    if (rst) begin
      avg_tc  <= '0;
      avg_out <= '0;
    end else begin
      if (s1_valid && last && !clear) avg_tc <= avg_n;
      if (done && !clear) avg_out <= tc2sm(avg_tc);
    end
`ifdef VOLT_PEAK_TRK_EN
  volt_peak_trk u_peak (
    .ad_clk   (ad_clk),
    .rst      (rst),
    .clear    (clear),
    .s1_valid (s1_valid),
    .first    (cnt == '0),
    .s1       (s1),
    .fire     (done),
    .max_out  (max_out),
    .min_out  (min_out),
    .pkpk_out (pkpk_out)
  );
`else
  assign max_out  = '0;
  assign min_out  = '0;
  assign pkpk_out = '0;
`endif
endmodule

// File: tb/tb_volt_win_avg.sv
// tb_volt_win_avg: directed plus random stimulus against a window-list reference model
module tb_volt_win_avg;
  localparam int L = 2;
  localparam int N = 1 << L;
  typedef struct {int due; logic [15:0] a, mx, mn, pp;} res_t;
  logic ad_clk = 1'b0;
  logic rst, in_valid, clear, avg_valid;
  logic [15:0] data_in, avg_out, max_out, min_out, pkpk_out;
  int n_cmp = 0, n_bad = 0, cyc = 0, pulses = 0, p0;
  int win[$];
  res_t pend[$];
  logic [15:0] e_avg = '0, e_max = '0, e_min = '0, e_pp = '0;
  volt_win_avg #(.LOG2_N(L)) dut (
    .ad_clk(ad_clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clear(clear),
    .avg_out(avg_out), .avg_valid(avg_valid), .max_out(max_out), .min_out(min_out),
    .pkpk_out(pkpk_out)
  );
  always #5 ad_clk = ~ad_clk;
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int sm2i(logic [15:0] x);
    return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
  endfunction
  function automatic logic [15:0] i2sm(int v);
    return v < 0 ? {1'b1, 15'(-v)} : {1'b0, 15'(v)};
  endfunction
  task automatic step(bit v, logic [15:0] d, bit c, bit r);
    bit ev = 0;
    int s, mx, mn, q;
    in_valid = v; data_in = d; clear = c; rst = r;
    @(posedge ad_clk);
    cyc++;
    if (r || c) begin
      win.delete();
      pend.delete();
      if (r) begin e_avg = '0; e_max = '0; e_min = '0; e_pp = '0; end
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        ev = 1; e_avg = pend[0].a; e_max = pend[0].mx; e_min = pend[0].mn; e_pp = pend[0].pp;
        void'(pend.pop_front());
      end
      if (v) begin
        win.push_back(sm2i(d));
        if (win.size() == N) begin
          s = 0; mx = win[0]; mn = win[0];
          foreach (win[i]) begin
            s += win[i];
            if (win[i] > mx) mx = win[i];
            if (win[i] < mn) mn = win[i];
          end
          q = s / N;
          if (s < 0 && q * N != s) q -= 1;
          pend.push_back('{cyc + 2, i2sm(q), i2sm(mx), i2sm(mn), 16'(mx - mn)});
          win.delete();
        end
      end
    end
    #1;
    if (avg_valid === 1'b1) pulses++;
    chk("avg_valid", {15'b0, avg_valid}, {15'b0, ev});
    chk("avg_out", avg_out, e_avg);
`ifdef VOLT_PEAK_TRK_EN
    chk("max_out", max_out, e_max);
    chk("min_out", min_out, e_min);
    chk("pkpk_out", pkpk_out, e_pp);
`else
    chk("max_out", max_out, 16'h0000);
    chk("min_out", min_out, 16'h0000);
    chk("pkpk_out", pkpk_out, 16'h0000);
`endif
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0);
  endtask
  initial begin
    logic [15:0] tp1[4] = '{16'h0064, 16'h00C8, 16'h012C, 16'h0190};
    logic [15:0] tp3[4] = '{16'h0003, 16'h8004, 16'h0000, 16'h8000};
    logic [15:0] d;
    step(0, 16'h0, 0, 1);
    step(1, 16'h1234, 1, 1);
    chk("reset_avg", avg_out, 16'h0000);
    foreach (tp1[i]) step(1, tp1[i], 0, 0);
    step(0, 16'h0, 0, 0);
    chk("tp1_no_early_valid", {15'b0, avg_valid}, 16'h0000);
    step(0, 16'h0, 0, 0);
    chk("tp1_valid_e2", {15'b0, avg_valid}, 16'h0001);
    chk("tp1_avg", avg_out, 16'h00FA);
    idle(2);
    for (int i = 0; i < 4; i++) step(1, 16'h8064, 0, 0);
    idle(3);
    chk("tp2_avg", avg_out, 16'h8064);
    foreach (tp3[i]) step(1, tp3[i], 0, 0);
    idle(3);
    chk("tp3_avg", avg_out, 16'h8001);
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin step(1, 16'h0008, 0, 0); step(0, 16'h7FFF, 0, 0); end
    idle(3);
    chk("tp4_pulses", 16'(pulses - p0), 16'd1);
    chk("tp4_avg", avg_out, 16'h0008);
    step(1, 16'd10, 0, 0);
    step(1, 16'd20, 0, 0);
    step(1, 16'd30, 1, 0);
    chk("tp5_clear_no_valid", {15'b0, avg_valid}, 16'h0000);
    for (int i = 0; i < 4; i++) step(1, 16'd40, 0, 0);
    idle(3);
    chk("tp5_avg", avg_out, 16'h0028);
    for (int i = 0; i < 3; i++) step(1, 16'd50, 0, 0);
    step(0, 16'h0, 0, 1);
    chk("tp6_rst_avg", avg_out, 16'h0000);
    p0 = pulses;
    for (int i = 0; i < 3; i++) step(1, 16'd60, 0, 0);
    idle(4);
    chk("tp6_no_pulse_3", 16'(pulses - p0), 16'd0);
    step(1, 16'd60, 0, 0);
    idle(3);
    chk("tp6_avg", avg_out, 16'd60);
    for (int i = 0; i < 3000; i++) begin
      d = {1'($urandom), 15'($urandom_range(0, 32767))};
      if ($urandom_range(0, 19) == 0) d = 16'h8000;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
